lc3_operand_fetch: RTL and testbench

Operand-fetch stage for the LC-3 datapath, sitting between instruction decode and the register file. It accepts a 16-bit instruction over a valid/ready handshake and decodes its register fields. It sequences reads through the register file's single registered read port (`out_reg` → `outdata`, one-cycle read latency) and delivers the opcode, destination register and both operands to the execute stage over a second valid/ready handshake.

---
 rtl/lc3_pkg.sv | 52 +++++
 rtl/lc3_sext.sv | 12 +
 rtl/lc3_operand_fetch.sv | 123 ++++++++++++
 tb/tb_lc3_operand_fetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions: opcodes, instruction field positions, operand-fetch FSM encoding
// and a small decode helper.
package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned DR_MSB   = 11;
    localparam int unsigned DR_LSB   = 9;
    localparam int unsigned SR1_MSB  = 8;
    localparam int unsigned SR1_LSB  = 6;
    localparam int unsigned IMM_FLAG = 5;
    localparam int unsigned IMM5_MSB = 4;
    localparam int unsigned IMM5_LSB = 0;
    localparam int unsigned SR2_MSB  = 2;
    localparam int unsigned SR2_LSB  = 0;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StIssueA = 3'd1;
    localparam logic [2:0] StIssueB = 3'd2;
    localparam logic [2:0] StCapB   = 3'd3;
    localparam logic [2:0] StValid  = 3'd4;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] dr;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic [4:0] imm5;
        logic       supported;
        logic       is_not;
        logic       reg_form;
    } decode_t;

    function automatic decode_t decode_instr(input logic [15:0] ir);
        decode_t d;
        d.opcode    = ir[OPC_MSB:OPC_LSB];
        d.dr        = ir[DR_MSB:DR_LSB];
        d.sr1       = ir[SR1_MSB:SR1_LSB];
        d.sr2       = ir[SR2_MSB:SR2_LSB];
        d.imm5      = ir[IMM5_MSB:IMM5_LSB];
        d.is_not    = (d.opcode == OP_NOT);
        d.supported = (d.opcode == OP_ADD) || (d.opcode == OP_AND) || d.is_not;
        // Only ADD/AND with the immediate flag clear need a second register read.
        d.reg_form  = ((d.opcode == OP_ADD) || (d.opcode == OP_AND)) && !ir[IMM_FLAG];
        return d;
    endfunction

endpackage

// File: rtl/lc3_sext.sv
// Sign extension of a narrow two's-complement field to the datapath width.
module lc3_sext #(
    parameter int unsigned IN_WIDTH  = 5,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  value,
    output logic [OUT_WIDTH-1:0] result
);

    assign result = {{(OUT_WIDTH - IN_WIDTH){value[IN_WIDTH-1]}}, value};

endmodule

// File: rtl/lc3_operand_fetch.sv
// LC-3 operand-fetch stage: accepts an instruction, reads its source registers through a
// single registered read port and presents opcode, DR and both operands to execute.
module lc3_operand_fetch
    import lc3_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [WIDTH-1:0] instr,
    output logic             instr_ready,
    output logic [2:0]       rf_out_reg,
    input  logic [WIDTH-1:0] rf_outdata,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [3:0]       op_opcode,
    output logic [2:0]       op_dr,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_unsupported
);

    logic [2:0]       state_q, state_d;
    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             unsup_q, unsup_d;

    decode_t          dec_ir;
    decode_t          dec_in;
    logic [WIDTH-1:0] imm_ext;

    assign dec_ir = decode_instr(ir_q);
    assign dec_in = decode_instr(instr);

    lc3_sext #(
        .IN_WIDTH (5),
        .OUT_WIDTH(WIDTH)
    ) u_imm5_sext (
        .value (dec_ir.imm5),
        .result(imm_ext)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        unsup_d = unsup_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid) begin
                    ir_d = instr;
                    if (dec_in.supported) begin
                        unsup_d = 1'b0;
                        state_d = StIssueA;
                    end else begin
                        unsup_d = 1'b1;
                        a_d     = '0;
                        b_d     = '0;
                        state_d = StValid;
                    end
                end
            end
            StIssueA: state_d = StIssueB;
            StIssueB: begin
                // Read data for SR1 arrives here, one cycle after the address was driven.
                a_d = rf_outdata;
                if (dec_ir.reg_form) begin
                    state_d = StCapB;
                end else begin
                    b_d     = dec_ir.is_not ? '0 : imm_ext;
                    state_d = StValid;
                end
            end
            StCapB: begin
                b_d     = rf_outdata;
                state_d = StValid;
            end
            StValid: begin
                if (op_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_out_reg = 3'd0;
        unique case (state_q)
            StIssueA: rf_out_reg = dec_ir.sr1;
            StIssueB: rf_out_reg = dec_ir.reg_form ? dec_ir.sr2 : 3'd0;
            default:  rf_out_reg = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            unsup_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            unsup_q <= unsup_d;
        end
    end

    assign instr_ready    = (state_q == StIdle);
    assign op_valid       = (state_q == StValid);
    assign op_opcode      = dec_ir.opcode;
    assign op_dr          = dec_ir.dr;
    assign op_a           = a_q;
    assign op_b           = b_q;
    assign op_unsupported = unsup_q;

endmodule

// File: tb/tb_lc3_operand_fetch.sv
// Directed plus randomized bench for lc3_operand_fetch against an instruction-level model.
module tb_lc3_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [2:0]  rf_out_reg;
    logic [15:0] rf_outdata;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_opcode;
    logic [2:0]  op_dr;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_unsupported;

    logic [15:0] regs [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External register file: registered read port, one-cycle latency.
    always @(posedge clk) rf_outdata <= regs[rf_out_reg];

    lc3_operand_fetch #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .rf_out_reg    (rf_out_reg),
        .rf_outdata    (rf_outdata),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_opcode     (op_opcode),
        .op_dr         (op_dr),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_unsupported(op_unsupported)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction-level model: what execute should receive, and how the reads should look.
    task automatic model(input logic [15:0] ins, output logic [15:0] ea, output logic [15:0] eb,
                         output logic uns, output int lat, output int n_reads,
                         output logic [2:0] r1, output logic [2:0] r2);
        int op;
        int imm;
        op      = int'(ins[15:12]);
        r1      = ins[8:6];
        r2      = ins[2:0];
        uns     = 1'b0;
        ea      = 16'd0;
        eb      = 16'd0;
        // Cycles after the accept cycle until op_valid: one per visited state.
        if (op == 1 || op == 5 || op == 9) begin
            ea = regs[r1];
            if (op == 9) begin
                eb = 16'd0; lat = 3; n_reads = 1;
            end else if (ins[5]) begin
                imm = int'(ins[4:0]);
                if (imm >= 16) imm = imm - 32;
                eb = 16'(imm); lat = 3; n_reads = 1;
            end else begin
                eb = regs[r2]; lat = 4; n_reads = 2;
            end
        end else begin
            uns = 1'b1; lat = 1; n_reads = 0;
        end
    endtask

    task automatic check_bundle(input logic [15:0] ins, input logic [15:0] ea,
                                input logic [15:0] eb, input logic uns);
        chk("op_valid",  32'(op_valid), 32'd1);
        chk("opcode",    32'(op_opcode), 32'(ins[15:12]));
        chk("dr",        32'(op_dr), 32'(ins[11:9]));
        chk("op_a",      32'(op_a), 32'(ea));
        chk("op_b",      32'(op_b), 32'(eb));
        chk("unsup",     32'(op_unsupported), 32'(uns));
        chk("ready_low", 32'(instr_ready), 32'd0);
    endtask

    // Entered and left just after a falling edge.
    task automatic run_instr(input logic [15:0] ins, input int stall);
        logic [15:0] ea, eb;
        logic        uns;
        int          lat, n_reads, cyc;
        logic [2:0]  r1, r2;
        logic [2:0]  rd [16];
        model(ins, ea, eb, uns, lat, n_reads, r1, r2);
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
        cyc         = 1;
        while (!op_valid && cyc < 12) begin
            rd[cyc] = rf_out_reg;
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(lat));
        if (n_reads >= 1) chk("rd_sr1", 32'(rd[1]), 32'(r1));
        if (n_reads == 2) chk("rd_sr2", 32'(rd[2]), 32'(r2));
        chk("rd_valid_zero", 32'(rf_out_reg), 32'd0);
        check_bundle(ins, ea, eb, uns);
        for (int i = 0; i < stall; i++) begin
            op_ready    = 1'b0;
            instr_valid = 1'($urandom_range(0, 1));
            instr       = 16'($urandom);
            @(negedge clk);
            check_bundle(ins, ea, eb, uns);
        end
        instr_valid = 1'b0;
        op_ready    = 1'b1;
        chk("ready_hs", 32'(instr_ready), 32'd0);
        @(negedge clk);
        op_ready = 1'b0;
        chk("valid_drop", 32'(op_valid), 32'd0);
        chk("ready_back", 32'(instr_ready), 32'd1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        w = 16'($urandom);
        case ($urandom_range(0, 4))
            0: w[15:12] = 4'b0001;
            1: w[15:12] = 4'b0101;
            2: w[15:12] = 4'b1001;
            3: begin w[15:12] = 4'b0001; w[5] = 1'b0; end
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 16'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'd0;
        op_ready    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(op_valid), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_rd",    32'(rf_out_reg), 32'd0);
        chk("rst_unsup", 32'(op_unsupported), 32'd0);
        chk("rst_a",     32'(op_a), 32'd0);
        chk("rst_b",     32'(op_b), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);

        regs[1] = 16'd5; regs[2] = 16'd7;
        regs[4] = 16'h00F0; regs[6] = 16'h1234;
        run_instr(16'h1642, 0);   // ADD R3,R1,R2
        run_instr(16'h513B, 0);   // AND R0,R4,#-5
        run_instr(16'h95BF, 0);   // NOT R2,R6
        run_instr(16'h2000, 0);   // LD: unsupported
        run_instr(16'h1642, 4);   // backpressure

        // Reset while in ISSUE_B, then a clean ADD.
        chk("ready_pre_mid", 32'(instr_ready), 32'd1);
        instr       = 16'h1A42;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("mid_rd_sr1", 32'(rf_out_reg), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(op_valid), 32'd0);
        chk("mid_rst_rd",    32'(rf_out_reg), 32'd0);
        chk("mid_rst_ready", 32'(instr_ready), 32'd1);
        run_instr(16'h1A42, 0);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
            run_instr(rand_instr(), int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
